// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the product-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } bcd_state_t;

  // Minimum number of decimal digits needed to represent 2**w - 1.
  function automatic int bcd_digits(int w);
    longint unsigned maxv;
    int d;
    maxv = (64'd1 << w) - 64'd1;
    d = 1;
    while (maxv >= 64'd10) begin
      maxv = maxv / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: turns the registered multiplier product into packed BCD.
//
//  state   | meaning
//  S_IDLE  | ready for a new value; accepts i_bin when i_valid=1
//  S_SHIFT | W add-3/shift iterations, one per cycle
//  S_DONE  | o_bcd holds the new result, o_valid pulses; back to idle next cycle
module product_bcd_converter
  import bcd_pkg::*;
#(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [W-1:0]      i_bin,
  output logic              o_ready,
  output logic              o_valid,
  output logic [4*DIGITS-1:0] o_bcd
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;

  if (DIGITS < bcd_digits(W)) begin : g_digits_check
    $error("product_bcd_converter: DIGITS too small for W-bit input");
  end

  bcd_state_t     state;
  logic [BW-1:0]  scratch;
  logic [BW-1:0]  adj;
  logic [BW-1:0]  scratch_nxt;
  logic [W-1:0]   shift;
  logic [CW-1:0]  cnt;
  logic           unused_adj_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d(scratch[4*g +: 4]),
      .q(adj[4*g +: 4])
    );
  end

  // The top bit of the corrected scratch is always shifted out; with enough digits it is 0.
  assign unused_adj_msb = adj[BW-1];
  assign scratch_nxt    = {adj[BW-2:0], shift[W-1]};
  assign o_ready        = (state == S_IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= S_IDLE;
      scratch <= '0;
      shift   <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_bcd   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          o_valid <= 1'b0;
          if (i_valid) begin
            shift   <= i_bin;
            scratch <= '0;
            cnt     <= CW'(W);
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch <= scratch_nxt;
          shift   <= {shift[W-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
          // Publish on the final shift so o_bcd never exposes partial scratch values.
          if (cnt == CW'(1)) begin
            o_bcd   <= scratch_nxt;
            o_valid <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          o_valid <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed self-checking bench for product_bcd_converter (W=16, DIGITS=5).
module tb_product_bcd_converter;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_valid;
  logic [15:0] i_bin;
  logic        o_ready;
  logic        o_valid;
  logic [19:0] o_bcd;

  int checks   = 0;
  int failures = 0;

  product_bcd_converter #(.W(16), .DIGITS(5)) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_valid  (i_valid),
    .i_bin    (i_bin),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_bcd    (o_bcd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [19:0] to_bcd(int unsigned v);
    logic [19:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Stimulus only: one accepted conversion, returns what was observed.
  task automatic run_one(input logic [15:0] v, output logic [19:0] bcd, output int lat,
                         output logic vld_next, output logic rdy_next);
    int n;
    n = 0;
    @(negedge i_clk);
    while (o_ready !== 1'b1 && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    i_valid = 1'b1;
    i_bin   = v;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_bin   = ~v;
    n = 1;
    while (o_valid !== 1'b1 && n < 40) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    lat = (o_valid === 1'b1) ? n : -1;
    bcd = o_bcd;
    @(posedge i_clk);
    #1;
    vld_next = o_valid;
    rdy_next = o_ready;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_bin     = '0;
    #12;
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++;
    if (o_bcd !== 20'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=00000", o_bcd); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got ready=%b valid=%b exp ready=1 valid=0", o_ready, o_valid);
    end
  endtask

  task automatic test_basic();
    logic [19:0] bcd;
    int lat;
    logic vn, rn;
    run_one(16'd65025, bcd, lat, vn, rn);
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    checks++;
    if (bcd !== 20'h65025) begin failures++; $display("FAIL basic_bcd got=%h exp=65025", bcd); end
    checks++;
    if (vn !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", vn); end
    checks++;
    if (rn !== 1'b1) begin failures++; $display("FAIL basic_ready_after got=%b exp=1", rn); end
  endtask

  task automatic test_zero_max();
    logic [19:0] bcd;
    int lat;
    logic vn, rn;
    run_one(16'd0, bcd, lat, vn, rn);
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL zero_latency got=%0d exp=17", lat); end
    checks++;
    if (bcd !== 20'h00000) begin failures++; $display("FAIL zero_bcd got=%h exp=00000", bcd); end
    run_one(16'hFFFF, bcd, lat, vn, rn);
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL max_latency got=%0d exp=17", lat); end
    checks++;
    if (bcd !== 20'h65535) begin failures++; $display("FAIL max_bcd got=%h exp=65535", bcd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    logic [19:0] exps [3];
    logic [19:0] res_bcd [3];
    int res_cyc [3];
    int acc, nres;
    vals[0] = 16'd99;   exps[0] = 20'h00099;
    vals[1] = 16'd100;  exps[1] = 20'h00100;
    vals[2] = 16'd9;    exps[2] = 20'h00009;
    acc = 0;
    nres = 0;
    for (int i = 0; i < 3; i++) begin res_bcd[i] = '0; res_cyc[i] = 0; end
    for (int c = 1; c <= 70; c++) begin
      @(negedge i_clk);
      if (o_ready === 1'b1) begin
        if (acc < 3) begin
          i_bin   = vals[acc];
          i_valid = 1'b1;
          acc++;
        end else begin
          i_valid = 1'b0;
        end
      end
      @(posedge i_clk);
      #1;
      if (o_valid === 1'b1) begin
        if (nres < 3) begin
          res_bcd[nres] = o_bcd;
          res_cyc[nres] = c;
        end
        nres++;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (nres !== 3) begin failures++; $display("FAIL b2b_pulse_count got=%0d exp=3", nres); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res_bcd[i] !== exps[i]) begin
        failures++;
        $display("FAIL b2b_bcd[%0d] got=%h exp=%h", i, res_bcd[i], exps[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (res_cyc[i] - res_cyc[i-1] !== 18) begin
        failures++;
        $display("FAIL b2b_spacing[%0d] got=%0d exp=18", i, res_cyc[i] - res_cyc[i-1]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int n, pulses;
    logic [19:0] bcd;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_bin   = 16'd1234;
    @(posedge i_clk);
    #1;
    // Keep presenting another value while the engine is busy.
    i_bin = 16'd4321;
    repeat (10) @(posedge i_clk);
    #1;
    checks++;
    if (o_ready !== 1'b0) begin failures++; $display("FAIL busy_ready got=%b exp=0", o_ready); end
    i_valid = 1'b0;
    n = 11;
    while (o_valid !== 1'b1 && n < 40) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    bcd = o_bcd;
    checks++;
    if (n !== 17) begin failures++; $display("FAIL busy_latency got=%0d exp=17", n); end
    checks++;
    if (bcd !== 20'h01234) begin failures++; $display("FAIL busy_bcd got=%h exp=01234", bcd); end
    pulses = 0;
    repeat (25) begin
      @(posedge i_clk);
      #1;
      if (o_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL busy_not_queued got=%0d pulses exp=0", pulses); end
    checks++;
    if (o_bcd !== 20'h01234) begin failures++; $display("FAIL busy_bcd_stable got=%h exp=01234", o_bcd); end
  endtask

  task automatic test_reset_mid();
    int pulses, lat;
    logic [19:0] bcd;
    logic vn, rn;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_bin   = 16'd12345;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (7) @(posedge i_clk);
    #3;
    checks++;
    if (o_ready !== 1'b0 || o_bcd !== 20'h01234) begin
      failures++;
      $display("FAIL midreset_pre got ready=%b bcd=%h exp ready=0 bcd=01234", o_ready, o_bcd);
    end
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_bcd !== 20'h0) begin failures++; $display("FAIL midreset_bcd got=%h exp=00000", o_bcd); end
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", o_ready); end
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", o_valid); end
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(posedge i_clk);
      #1;
      if (o_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL midreset_no_pulse got=%0d exp=0", pulses); end
    run_one(16'd42, bcd, lat, vn, rn);
    checks++;
    if (bcd !== 20'h00042 || lat !== 17) begin
      failures++;
      $display("FAIL after_reset_42 got bcd=%h lat=%0d exp bcd=00042 lat=17", bcd, lat);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] v;
    logic [19:0] bcd, exp_bcd;
    int lat, bad_digit;
    logic vn, rn;
    for (int i = 0; i < 200; i++) begin
      case (i)
        0: v = 16'd9;
        1: v = 16'd10;
        2: v = 16'd9999;
        3: v = 16'd10000;
        4: v = 16'd59999;
        default: v = 16'($urandom_range(0, 65535));
      endcase
      exp_bcd = to_bcd(int'(v));
      run_one(v, bcd, lat, vn, rn);
      checks++;
      if (bcd !== exp_bcd) begin
        failures++;
        $display("FAIL sweep_bcd v=%0d got=%h exp=%h", v, bcd, exp_bcd);
      end
      bad_digit = 0;
      for (int d = 0; d < 5; d++) if (bcd[4*d +: 4] > 4'd9) bad_digit++;
      checks++;
      if (bad_digit !== 0) begin
        failures++;
        $display("FAIL sweep_digit_range v=%0d got=%h exp all digits <=9", v, bcd);
      end
      checks++;
      if (lat !== 17 || vn !== 1'b0) begin
        failures++;
        $display("FAIL sweep_timing v=%0d got lat=%0d next_valid=%b exp lat=17 next_valid=0", v, lat, vn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_max();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
